// File: rtl/ebpf_ldx_extend_ctrl.sv
// eBPF LDX / LDX-SX load sequencer: issues one or two word reads, extracts the
// addressed B/H/W field or assembles a DW, and extends the result to 64 bits.
module ebpf_ldx_extend_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [3:0]        req_rd,
  output logic              mem_rd_valid,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ready,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  input  logic              mem_rsp_err,
  output logic              res_valid,
  output logic [63:0]       res_data,
  output logic [3:0]        res_rd,
  output logic              res_err,
  input  logic              res_ready,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE0 = 3'd1,
    WAIT0  = 3'd2,
    ISSUE1 = 3'd3,
    WAIT1  = 3'd4,
    RESP   = 3'd5
  } state_t;

  localparam logic [1:0] SZ_B  = 2'b00;
  localparam logic [1:0] SZ_H  = 2'b01;
  localparam logic [1:0] SZ_DW = 2'b11;

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [1:0]          size_r;
  logic                signed_r;
  logic [31:0]         lo_r;
  logic [63:0]         res_data_r;
  logic                res_err_r;
  logic [3:0]          res_rd_r;
  logic [ADDR_W-1:0]   base_addr_s;
  logic                misaligned_s;

  function automatic logic misaligned_f(input logic [2:0] a, input logic [1:0] sz);
    case (sz)
      2'b00:   misaligned_f = 1'b0;
      2'b01:   misaligned_f = a[0];
      2'b10:   misaligned_f = (a[1:0] != 2'b00);
      2'b11:   misaligned_f = (a[2:0] != 3'b000);
      default: misaligned_f = 1'b1;
    endcase
  endfunction

  // Little-endian lane select followed by sign or zero extension to 64 bits.
  function automatic logic [63:0] extend_f(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [1:0] sz, input logic sgn);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    sh_b = word >> {lane, 3'b000};
    sh_h = word >> {lane[1], 4'b0000};
    case (sz)
      2'b00:   extend_f = {{56{sgn & sh_b[7]}}, sh_b[7:0]};
      2'b01:   extend_f = {{48{sgn & sh_h[15]}}, sh_h[15:0]};
      default: extend_f = {{32{sgn & word[31]}}, word};
    endcase
  endfunction

  assign misaligned_s = misaligned_f(req_addr[2:0], req_size);
  assign base_addr_s  = {addr_r[ADDR_W-1:2], 2'b00};

  assign req_ready    = (state_r == IDLE);
  assign busy         = (state_r != IDLE);
  assign res_valid    = (state_r == RESP);
  assign res_data     = res_data_r;
  assign res_err      = res_err_r;
  assign res_rd       = res_rd_r;
  assign mem_rd_valid = (state_r == ISSUE0) || (state_r == ISSUE1);
  assign mem_rd_addr  = (state_r == ISSUE0) ? base_addr_s :
                        (state_r == ISSUE1) ? base_addr_s + ADDR_W'(4) : '0;

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) state_s = misaligned_s ? RESP : ISSUE0;
        else           state_s = IDLE;
      end
      ISSUE0: begin
        if (mem_rd_ready) state_s = WAIT0;
        else              state_s = ISSUE0;
      end
      WAIT0: begin
        if (mem_rsp_valid) begin
          if (!mem_rsp_err && size_r == SZ_DW) state_s = ISSUE1;
          else                                 state_s = RESP;
        end else begin
          state_s = WAIT0;
        end
      end
      ISSUE1: begin
        if (mem_rd_ready) state_s = WAIT1;
        else              state_s = ISSUE1;
      end
      WAIT1: begin
        if (mem_rsp_valid) state_s = RESP;
        else               state_s = WAIT1;
      end
      RESP: begin
        if (res_ready) state_s = IDLE;
        else           state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Request capture, beat assembly and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r     <= '0;
      size_r     <= 2'b00;
      signed_r   <= 1'b0;
      lo_r       <= 32'd0;
      res_data_r <= 64'd0;
      res_err_r  <= 1'b0;
      res_rd_r   <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            addr_r     <= req_addr;
            size_r     <= req_size;
            signed_r   <= req_signed;
            res_rd_r   <= req_rd;
            res_err_r  <= misaligned_s;
            res_data_r <= 64'd0;
          end
        end
        WAIT0: begin
          if (mem_rsp_valid) begin
            if (mem_rsp_err) begin
              res_err_r  <= 1'b1;
              res_data_r <= 64'd0;
            end else if (size_r == SZ_DW) begin
              lo_r <= mem_rsp_data;
            end else begin
              res_err_r  <= 1'b0;
              res_data_r <= extend_f(mem_rsp_data, addr_r[1:0], size_r, signed_r);
            end
          end
        end
        WAIT1: begin
          if (mem_rsp_valid) begin
            res_err_r  <= mem_rsp_err;
            res_data_r <= mem_rsp_err ? 64'd0 : {mem_rsp_data, lo_r};
          end
        end
        RESP: begin
          // Clear after handshake so an idle controller presents a zero result.
          if (res_ready) begin
            res_data_r <= 64'd0;
            res_err_r  <= 1'b0;
            res_rd_r   <= 4'd0;
          end
        end
        default: begin
          lo_r <= lo_r;
        end
      endcase
    end
  end

endmodule
